// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution output-stream collector.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } collector_state_t;

  localparam int DEFAULT_FRAME_PIX = 25;
  localparam int FCNT_BITS         = 16;

endpackage

// File: rtl/pix_ram.sv
// Frame buffer: one synchronous write port, one synchronous read port.
// A same-cycle read of the address being written returns the old contents.
module pix_ram #(
  parameter  int D_BITS = 8,
  parameter  int DEPTH  = 25,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [D_BITS-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [D_BITS-1:0] rdata
);

  logic [D_BITS-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/conv_frame_collector.sv
// Captures one FRAME_PIX-byte convolution output frame, publishes sum/min/max,
// and holds the buffer for random-access readback until acknowledged.
module conv_frame_collector
  import conv_pkg::*;
#(
  parameter int D_BITS    = 8,
  parameter int FRAME_PIX = DEFAULT_FRAME_PIX,
  parameter int ADDR_BITS = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1,
  parameter int SUM_BITS  = D_BITS + ADDR_BITS + 1
) (
  input  logic                 i_clk,
  input  logic                 reset,
  input  logic [D_BITS-1:0]    i_data,
  input  logic                 i_dvalid,
  input  logic                 i_ack,
  input  logic                 i_rd_en,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [D_BITS-1:0]    o_rd_data,
  output logic                 o_rd_valid,
  output logic                 o_frame_done,
  output logic                 o_holding,
  output logic [SUM_BITS-1:0]  o_sum,
  output logic [D_BITS-1:0]    o_min,
  output logic [D_BITS-1:0]    o_max,
  output logic [FCNT_BITS-1:0] o_frame_cnt,
  output logic                 o_overrun
);

  localparam int                   RAM_AW    = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FRAME_PIX - 1);
  localparam logic                 ONE_PIX   = (FRAME_PIX == 1);

  collector_state_t     state;
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [SUM_BITS-1:0]  acc_sum;
  logic [D_BITS-1:0]    acc_min, acc_max;
  logic                 rd_valid_q, rd_hit_q;

  logic                 start, accept, last, rd_in_range;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [SUM_BITS-1:0]  nxt_sum;
  logic [D_BITS-1:0]    nxt_min, nxt_max, ram_q;

  // A byte opens a new frame from IDLE, or from HOLD when the ack lands with it.
  always_comb begin
    start       = i_dvalid && (state == IDLE || (state == HOLD && i_ack));
    accept      = start || (i_dvalid && state == FILL);
    wr_addr     = start ? '0 : wr_ptr;
    last        = start ? ONE_PIX : (wr_ptr == LAST_ADDR);
    nxt_sum     = start ? SUM_BITS'(i_data) : acc_sum + SUM_BITS'(i_data);
    nxt_min     = (start || i_data < acc_min) ? i_data : acc_min;
    nxt_max     = (start || i_data > acc_max) ? i_data : acc_max;
    rd_in_range = int'(i_rd_addr) < FRAME_PIX;
  end

  pix_ram #(
    .D_BITS (D_BITS),
    .DEPTH  (FRAME_PIX)
  ) u_ram (
    .i_clk (i_clk),
    .we    (accept),
    .waddr (RAM_AW'(wr_addr)),
    .wdata (i_data),
    .re    (i_rd_en && rd_in_range),
    .raddr (RAM_AW'(i_rd_addr)),
    .rdata (ram_q)
  );

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      acc_sum      <= '0;
      acc_min      <= '0;
      acc_max      <= '0;
      o_sum        <= '0;
      o_min        <= '0;
      o_max        <= '0;
      o_frame_cnt  <= '0;
      o_frame_done <= 1'b0;
      o_holding    <= 1'b0;
      o_overrun    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_hit_q     <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      rd_valid_q   <= i_rd_en;
      rd_hit_q     <= i_rd_en && rd_in_range;
      if (accept) begin
        acc_sum <= nxt_sum;
        acc_min <= nxt_min;
        acc_max <= nxt_max;
        if (last) begin
          o_sum        <= nxt_sum;
          o_min        <= nxt_min;
          o_max        <= nxt_max;
          o_frame_cnt  <= o_frame_cnt + 1'b1;
          o_frame_done <= 1'b1;
          o_holding    <= 1'b1;
          state        <= HOLD;
          wr_ptr       <= '0;
        end else begin
          o_holding    <= 1'b0;
          state        <= FILL;
          wr_ptr       <= wr_addr + ADDR_BITS'(1);
        end
      end else if (state == HOLD) begin
        if (i_ack) begin
          state     <= IDLE;
          o_holding <= 1'b0;
        end else if (i_dvalid) begin
          o_overrun <= 1'b1;
        end
      end
    end
  end

  // Out-of-range reads return zero; the RAM itself is never indexed past DEPTH.
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_hit_q ? ram_q : '0;

endmodule

// File: tb/tb_conv_frame_collector.sv
// Scoreboarded bench for conv_frame_collector: frame capture, stats, hold/ack,
// overrun, reset mid-frame and readback corner cases.
module tb_conv_frame_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  i_data = '0;
  logic        i_dvalid = 1'b0, i_ack = 1'b0, i_rd_en = 1'b0;
  logic [4:0]  i_rd_addr = '0;
  logic [7:0]  o_rd_data, o_min, o_max;
  logic        o_rd_valid, o_frame_done, o_holding, o_overrun;
  logic [13:0] o_sum;
  logic [15:0] o_frame_cnt;

  int checks = 0, failures = 0;
  logic [7:0]  rdq [$];
  logic [7:0]  mem_m [25];
  logic [13:0] pub_sum = '0;
  logic [7:0]  pub_min = '0, pub_max = '0;
  logic [15:0] exp_cnt = '0;

  always #5 clk = ~clk;

  conv_frame_collector dut (
    .i_clk(clk), .reset(reset), .i_data(i_data), .i_dvalid(i_dvalid),
    .i_ack(i_ack), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_frame_done(o_frame_done),
    .o_holding(o_holding), .o_sum(o_sum), .o_min(o_min), .o_max(o_max),
    .o_frame_cnt(o_frame_cnt), .o_overrun(o_overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, optionally queue an expected read, return #1 after the edge.
  task automatic cyc(input logic dv, input logic [7:0] d, input logic ack,
                     input logic rd, input logic [4:0] a, input logic [7:0] exp);
    i_dvalid = dv; i_data = d; i_ack = ack; i_rd_en = rd; i_rd_addr = a;
    if (rd) rdq.push_back(exp);
    @(posedge clk); #1;
    i_dvalid = 1'b0; i_ack = 1'b0; i_rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00);
  endtask

  task automatic read_all();
    for (int a = 0; a < 25; a++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 5'(a), mem_m[a]);
  endtask

  task automatic check_zero_outputs();
    check_eq("rst_sum", o_sum, 0);
    check_eq("rst_min", o_min, 0);
    check_eq("rst_max", o_max, 0);
    check_eq("rst_cnt", o_frame_cnt, 0);
    check_eq("rst_done", o_frame_done, 0);
    check_eq("rst_hold", o_holding, 0);
    check_eq("rst_ovr", o_overrun, 0);
    check_eq("rst_rdv", o_rd_valid, 0);
    check_eq("rst_rdd", o_rd_data, 0);
  endtask

  // kind: 0 = i+1, 1 = 0xFF, 2 = 0x00, other = random. rw5 reads addr 5 as it is written.
  task automatic send_frame(input int kind, input int start_idx, input logic rw5);
    logic [7:0]  v;
    logic [13:0] s;
    logic [7:0]  mn, mx;
    for (int i = start_idx; i < 25; i++) begin
      case (kind)
        0: v = 8'(i + 1);
        1: v = 8'hFF;
        2: v = 8'h00;
        default: v = 8'($urandom);
      endcase
      idle($urandom_range(0, 3));
      if (rw5 && i == 5) cyc(1'b1, v, 1'b0, 1'b1, 5'd5, mem_m[5]);
      else               cyc(1'b1, v, 1'b0, 1'b0, 5'd0, 8'h00);
      mem_m[i] = v;
      if (i < 24) begin
        check_eq("done_early", o_frame_done, 0);
        check_eq("sum_held", o_sum, pub_sum);
        check_eq("min_held", o_min, pub_min);
        check_eq("max_held", o_max, pub_max);
      end
    end
    s = '0; mn = 8'hFF; mx = 8'h00;
    for (int i = 0; i < 25; i++) begin
      s = s + 14'(mem_m[i]);
      if (mem_m[i] < mn) mn = mem_m[i];
      if (mem_m[i] > mx) mx = mem_m[i];
    end
    pub_sum = s; pub_min = mn; pub_max = mx; exp_cnt = exp_cnt + 1'b1;
    check_eq("done_pulse", o_frame_done, 1);
    check_eq("holding", o_holding, 1);
    check_eq("sum", o_sum, pub_sum);
    check_eq("min", o_min, pub_min);
    check_eq("max", o_max, pub_max);
    check_eq("frame_cnt", o_frame_cnt, exp_cnt);
    idle(1);
    check_eq("done_once", o_frame_done, 0);
    if (rw5) cyc(1'b0, 8'h00, 1'b0, 1'b1, 5'd5, mem_m[5]);
  endtask

  // Read monitor: every valid beat must match the oldest queued expectation.
  always @(negedge clk) begin
    if (o_rd_valid) begin
      if (rdq.size() == 0) check_eq("rd_spurious", o_rd_valid, 0);
      else check_eq("rd_data", o_rd_data, rdq.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < 25; i++) mem_m[i] = 8'h00;
    idle(2);
    reset = 1'b0;
    check_zero_outputs();

    // Frame 1: ramp 1..25 -> 325 / 1 / 25
    send_frame(0, 0, 1'b0);
    check_eq("f1_sum_const", o_sum, 325);
    read_all();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 5'd30, 8'h00);

    // ack and pixel 0 in the same HOLD cycle; rest random with a read-during-write at 5
    cyc(1'b1, 8'h5A, 1'b1, 1'b0, 5'd0, 8'h00);
    mem_m[0] = 8'h5A;
    check_eq("ackdv_hold", o_holding, 0);
    check_eq("ackdv_ovr", o_overrun, 0);
    send_frame(3, 1, 1'b1);
    check_eq("ackdv_ovr2", o_overrun, 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 8'h5A);
    read_all();

    // Three bytes dropped while holding
    repeat (3) cyc(1'b1, 8'h77, 1'b0, 1'b0, 5'd0, 8'h00);
    check_eq("ovr_set", o_overrun, 1);
    check_eq("ovr_hold", o_holding, 1);
    check_eq("ovr_sum", o_sum, pub_sum);
    check_eq("ovr_cnt", o_frame_cnt, exp_cnt);
    read_all();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00);
    check_eq("ack_release", o_holding, 0);

    // All 0xFF then all 0x00; stats held through the zero frame's fill
    send_frame(1, 0, 1'b0);
    check_eq("ff_sum_const", o_sum, 6375);
    check_eq("ovr_sticky", o_overrun, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00);
    send_frame(2, 0, 1'b0);
    read_all();

    // Reset after 10 bytes of a new frame
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'(100 + i), 1'b0, 1'b0, 5'd0, 8'h00);
      mem_m[i] = 8'(100 + i);
    end
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check_zero_outputs();
    pub_sum = '0; pub_min = '0; pub_max = '0; exp_cnt = '0;
    send_frame(0, 0, 1'b0);
    check_eq("post_rst_cnt", o_frame_cnt, 1);
    read_all();

    idle(3);
    check_eq("rd_drain", rdq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_frame_collector.md
# conv_frame_collector

Downstream sink for the convolution output stream after the second UART receiver. Captures one complete output frame of `FRAME_PIX` bytes from the `o_data`/`o_dvalid` byte stream into a local buffer. Computes per-frame sum/min/max and holds the frame for random-access readback until released by an acknowledge. Gives the test harness and any later host interface a stable, checkable copy of each convolved frame.

## Interface
Parameters:
- `D_BITS`, 8, pixel width
- `FRAME_PIX`, 25, bytes per output frame (5x5 result of a 7x7 image)
- `ADDR_BITS`, `$clog2(FRAME_PIX)`, buffer address width
- `SUM_BITS`, `D_BITS + ADDR_BITS + 1`, running-sum width; sized so it cannot overflow

Ports:
- `i_clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high; one clock, sampled on the rising edge of `i_clk`
- `i_data`  in  `D_BITS`  received pixel byte
- `i_dvalid`  in  1  one-cycle strobe; `i_data` valid
- `i_ack`  in  1  release held frame
- `i_rd_en`  in  1  readback request
- `i_rd_addr`  in  `ADDR_BITS`  readback address
- `o_rd_data`  out  `D_BITS`  readback byte
- `o_rd_valid`  out  1  readback data valid
- `o_frame_done`  out  1  one-cycle pulse when a frame is complete
- `o_holding`  out  1  frame held, readback stable
- `o_sum`  out  `SUM_BITS`  sum of last completed frame
- `o_min`  out  `D_BITS`  minimum of last completed frame
- `o_max`  out  `D_BITS`  maximum of last completed frame
- `o_frame_cnt`  out  16  completed frames; wraps 0xFFFF→0
- `o_overrun`  out  1  sticky; a byte was dropped while holding

## Operation
- FSM states: IDLE, FILL, HOLD.
- IDLE:
  - `i_dvalid` → write byte at addr 0, init accumulators (sum=byte, min=max=byte), wr_ptr=1, go to FILL.
  - Exception: if `FRAME_PIX`==1, go straight to HOLD via the completion path.
- FILL:
  - Each `i_dvalid` writes at wr_ptr, adds to sum, updates min/max, increments wr_ptr.
  - When the byte at `FRAME_PIX-1` is written, the completion path runs:
    - Publish sum/min/max to `o_sum`/`o_min`/`o_max`.
    - Increment `o_frame_cnt`.
    - Pulse `o_frame_done`.
    - Go to HOLD.
  - Gaps between strobes of any length are legal.
- HOLD:
  - Buffer is frozen and `o_holding`=1.
  - `i_dvalid` without `i_ack` → byte dropped, `o_overrun`←1.
  - `i_ack` alone → IDLE.
  - `i_ack` and `i_dvalid` in the same cycle → byte accepted as pixel 0 of the next frame, go to FILL; no overrun.
- `i_ack` in IDLE or FILL is ignored.
- Published stats are unchanged until the next completion. They remain valid through the following FILL.
- Readback is legal in every state:
  - Synchronous read port, independent of the write path.
  - Address ≥ `FRAME_PIX` returns 0 with `o_rd_valid`=1.
  - A read of the address being written in the same cycle returns the old contents (read-before-write).
- Arithmetic:
  - Pixels are unsigned.
  - Sum is zero-extended; no saturation is needed.
  - min/max compare is unsigned.
- `o_overrun` clears only on `reset`.

## Timing
- Reset values:
  - State IDLE, wr_ptr 0.
  - All outputs 0, including `o_min`, `o_max`, `o_rd_data`.
  - Buffer contents are not cleared.
- Reset mid-frame discards the partial frame. The published stats and frame count are also zeroed.
- Write: a byte sampled with `i_dvalid` in cycle N is in RAM by N+1.
- Completion:
  - Last byte sampled in cycle N → `o_frame_done`=1 in N+1 only.
  - `o_holding`, the new stats and the new `o_frame_cnt` all become visible in N+1.
- Release: `i_ack` sampled in cycle N → `o_holding`=0 in N+1.
- Read latency 1: `i_rd_en` in cycle N → `o_rd_data`/`o_rd_valid` in N+1. `o_rd_valid` is low whenever `i_rd_en` was low the previous cycle.
- Throughput: one byte per cycle sustained. Back-to-back strobes never lose data outside HOLD.

## Structure
- Shared package `conv_pkg`:
  - `collector_state_t` enum (IDLE, FILL, HOLD).
  - `DEFAULT_FRAME_PIX` constant.
  - Frame-count width constant.
- Sub-module `pix_ram`:
  - Parameters `D_BITS`, `DEPTH`.
  - One synchronous write port and one synchronous read port; read-before-write.
  - No reset on the storage array.
- FSM, accumulators and publish registers live in the top module.

## Test plan
- Stream bytes 1..25 with gaps of 0–3 cycles → `o_frame_done` pulses once, one cycle after byte 25. Expected: `o_sum`=325, `o_min`=1, `o_max`=25, `o_frame_cnt`=1. Reads of addr 0..24 return 1..25 with 1-cycle latency.
- Frame of all 0xFF → `o_sum`=6375, `o_min`=`o_max`=0xFF; no overflow. Next frame of all 0x00 → stats stay 6375/0xFF/0xFF until its completion, then become 0/0/0.
- During HOLD send 3 bytes with no ack → `o_overrun`=1, buffer and stats unchanged. Then `i_ack` → IDLE; the next 25 bytes form frame 2 correctly.
- `i_ack` and `i_dvalid`(0x5A) in the same HOLD cycle → no overrun; after 24 more bytes, addr 0 reads 0x5A.
- Assert `reset` after 10 bytes → all outputs 0 next cycle. The next 25 bytes complete a frame with `o_frame_cnt`=1.
- Reads: read addr 30 → 0 with valid. Same-cycle read and write at addr 5 in FILL → old value, new value on the following read.
